// File: rtl/ps2_rx_if.sv
// Key-event bus from the PS/2 receiver to the keyboard-to-game mapper.
// The receiver drives it through the master modport; the consumer reads it through the slave modport.
interface ps2_rx_if;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;
  logic       frame_err;

  // key_valid is a one-cycle strobe with no ready: the consumer must take key_code/key_ext/key_release
  // in the strobe cycle (they stay held until the next strobe). frame_err is an independent one-cycle
  // strobe and never coincides with key_valid.
  modport master (output key_code, key_ext, key_release, key_valid, frame_err);
  modport slave  (input  key_code, key_ext, key_release, key_valid, frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw lines, deserialises 11-bit frames,
// folds E0/F0 prefixes into flags and emits one key event per make or break code.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  ps2_rx_if.master    key_if,
  output logic [1:0]  dbg_state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  // Abort fires when the counter is about to reach TIMEOUT_CYCLES-1, so the registered
  // frame_err lands exactly TIMEOUT_CYCLES cycles after the last strobe.
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          strobe_q, strobe_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d, key_release_q, key_release_d;
  logic          key_valid_q, key_valid_d, frame_err_q, frame_err_d;

  // Input conditioning: the filter counts consecutive samples that disagree with the filtered level.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FLT_LAST) begin
        filt_clk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    strobe_d = filt_clk_q & ~filt_clk_d;
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    to_cnt_d      = to_cnt_q;
    shift_d       = shift_q;
    ext_d         = ext_q;
    rel_d         = rel_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    key_valid_d   = 1'b0;
    frame_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        if (strobe_q && !dat_s2_q) state_d = RECV;
      end
      RECV: begin
        if (strobe_q) begin
          // LSB-first: after ten strobes shift_q = {stop, parity, d7..d0}.
          shift_d  = {dat_s2_q, shift_q[9:1]};
          to_cnt_d = '0;
          if (bit_cnt_q == 4'd9) state_d = CHECK;
          else                   bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (to_cnt_q == TO_LAST) begin
          frame_err_d = 1'b1;
          ext_d       = 1'b0;
          rel_d       = 1'b0;
          state_d     = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!(^shift_q[8:0]) || !shift_q[9]) begin
          frame_err_d = 1'b1;
          ext_d       = 1'b0;
          rel_d       = 1'b0;
        end else if (shift_q[7:0] == 8'hE0) begin
          ext_d = 1'b1;
        end else if (shift_q[7:0] == 8'hF0) begin
          rel_d = 1'b1;
        end else begin
          key_code_d    = shift_q[7:0];
          key_ext_d     = ext_q;
          key_release_d = rel_q;
          key_valid_d   = 1'b1;
          ext_d         = 1'b0;
          rel_d         = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      clk_s1_q      <= 1'b1;
      clk_s2_q      <= 1'b1;
      dat_s1_q      <= 1'b1;
      dat_s2_q      <= 1'b1;
      filt_clk_q    <= 1'b1;
      filt_cnt_q    <= '0;
      strobe_q      <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      shift_q       <= '0;
      ext_q         <= 1'b0;
      rel_q         <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      clk_s1_q      <= clk_s1_d;
      clk_s2_q      <= clk_s2_d;
      dat_s1_q      <= dat_s1_d;
      dat_s2_q      <= dat_s2_d;
      filt_clk_q    <= filt_clk_d;
      filt_cnt_q    <= filt_cnt_d;
      strobe_q      <= strobe_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      shift_q       <= shift_d;
      ext_q         <= ext_d;
      rel_q         <= rel_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
      key_valid_q   <= key_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign key_if.key_code    = key_code_q;
  assign key_if.key_ext     = key_ext_q;
  assign key_if.key_release = key_release_q;
  assign key_if.key_valid   = key_valid_q;
  assign key_if.frame_err   = frame_err_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames on the raw lines and checks key events,
// errors, prefix folding, timeout, glitch rejection and mid-frame reset.
module tb_ps2_rx;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 600;
  localparam int HALF           = 20;
  // Raw fall -> 2 sync + FILTER_LEN filter cycles -> strobe, then CHECK, then the pulse.
  localparam int EDGE_LAT       = 2 + FILTER_LEN + 2;
  localparam int TO_LAT         = 2 + FILTER_LEN + TIMEOUT_CYCLES;

  logic       board_clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [1:0] dbg_state;

  ps2_rx_if key_if();

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_if    (key_if),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 board_clk = ~board_clk;

  int cyc = 0;
  always @(posedge board_clk) cyc <= cyc + 1;

  // Monitor: counts pulses and remembers when they were seen
  int n_valid = 0, n_err = 0, n_both = 0, n_busy = 0;
  int valid_cyc = 0, err_cyc = 0, fall_cyc = 0;
  always @(negedge board_clk) begin
    if (key_if.key_valid) begin n_valid++; valid_cyc = cyc; end
    if (key_if.frame_err) begin n_err++;   err_cyc   = cyc; end
    if (key_if.key_valid && key_if.frame_err) n_both++;
    if (dbg_state != 2'd0) n_busy++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge board_clk);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ par_flip);
    send_bit(stop);
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  int v0, e0, b0, to_fall;
  logic [7:0] part;

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    check_eq("rst_code",    {24'd0, key_if.key_code}, 32'h00);
    check_eq("rst_ext",     {31'd0, key_if.key_ext}, 32'd0);
    check_eq("rst_rel",     {31'd0, key_if.key_release}, 32'd0);
    check_eq("rst_valid",   {31'd0, key_if.key_valid}, 32'd0);
    check_eq("rst_err",     {31'd0, key_if.frame_err}, 32'd0);
    check_eq("rst_state",   {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    wait_cyc(5);

    // Plain make code 1C
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("1c_nvalid",  n_valid - v0, 1);
    check_eq("1c_nerr",    n_err - e0, 0);
    check_eq("1c_code",    {24'd0, key_if.key_code}, 32'h1C);
    check_eq("1c_ext",     {31'd0, key_if.key_ext}, 32'd0);
    check_eq("1c_rel",     {31'd0, key_if.key_release}, 32'd0);
    check_eq("1c_latency", valid_cyc - fall_cyc, EDGE_LAT);

    // Break: F0 1C, then a fresh make 1C
    v0 = n_valid;
    send_frame(8'hF0, 1'b0, 1'b1);
    check_eq("f0_nvalid",  n_valid - v0, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("brk_nvalid", n_valid - v0, 1);
    check_eq("brk_code",   {24'd0, key_if.key_code}, 32'h1C);
    check_eq("brk_rel",    {31'd0, key_if.key_release}, 32'd1);
    check_eq("brk_ext",    {31'd0, key_if.key_ext}, 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("mk2_rel",    {31'd0, key_if.key_release}, 32'd0);

    // Extended break: E0 F0 75, then 29 must see cleared flags
    v0 = n_valid;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check_eq("ext_nvalid", n_valid - v0, 1);
    check_eq("ext_code",   {24'd0, key_if.key_code}, 32'h75);
    check_eq("ext_ext",    {31'd0, key_if.key_ext}, 32'd1);
    check_eq("ext_rel",    {31'd0, key_if.key_release}, 32'd1);
    send_frame(8'h29, 1'b0, 1'b1);
    check_eq("clr_code",   {24'd0, key_if.key_code}, 32'h29);
    check_eq("clr_ext",    {31'd0, key_if.key_ext}, 32'd0);
    check_eq("clr_rel",    {31'd0, key_if.key_release}, 32'd0);

    // Bad parity, then bad stop bit
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1);
    check_eq("par_nerr",    n_err - e0, 1);
    check_eq("par_nvalid",  n_valid - v0, 0);
    check_eq("par_code",    {24'd0, key_if.key_code}, 32'h29);
    check_eq("par_latency", err_cyc - fall_cyc, EDGE_LAT);
    send_frame(8'h29, 1'b0, 1'b0);
    check_eq("stop_nerr",   n_err - e0, 2);
    check_eq("stop_nvalid", n_valid - v0, 0);

    // Timeout: start bit + 5 data bits, then the clock stays high
    v0 = n_valid; e0 = n_err;
    part = 8'h29;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(part[i]);
    to_fall = fall_cyc;
    for (int i = 0; i < TIMEOUT_CYCLES + 100 && n_err == e0; i++) wait_cyc(1);
    check_eq("to_nerr",    n_err - e0, 1);
    check_eq("to_latency", err_cyc - to_fall, TO_LAT);
    check_eq("to_nvalid",  n_valid - v0, 0);
    ps2_data = 1'b1;
    send_frame(8'h29, 1'b0, 1'b1);
    check_eq("after_to_nvalid", n_valid - v0, 1);
    check_eq("after_to_code",   {24'd0, key_if.key_code}, 32'h29);

    // Short ps2_clk low pulses while idle, data low so a false edge would look like a start bit
    b0 = n_busy; v0 = n_valid; e0 = n_err;
    for (int g = 0; g < 2; g++) begin
      @(negedge board_clk);
      ps2_data = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(g == 0 ? 4 : FILTER_LEN - 1);
      ps2_clk = 1'b1;
      wait_cyc(HALF);
      ps2_data = 1'b1;
    end
    wait_cyc(TIMEOUT_CYCLES / 4);
    check_eq("glitch_busy",   n_busy - b0, 0);
    check_eq("glitch_events", (n_valid - v0) + (n_err - e0), 0);

    // Reset after bit 4 of a frame discards it
    v0 = n_valid; e0 = n_err;
    part = 8'h75;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i]);
    @(negedge board_clk);
    reset = 1'b1;
    wait_cyc(2);
    check_eq("mrst_state", {30'd0, dbg_state}, 32'd0);
    check_eq("mrst_code",  {24'd0, key_if.key_code}, 32'h00);
    reset = 1'b0;
    ps2_data = 1'b1;
    wait_cyc(30);
    check_eq("mrst_events", (n_valid - v0) + (n_err - e0), 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("post_rst_nvalid", n_valid - v0, 1);
    check_eq("post_rst_code",   {24'd0, key_if.key_code}, 32'h1C);
    check_eq("post_rst_ext",    {31'd0, key_if.key_ext}, 32'd0);
    check_eq("post_rst_rel",    {31'd0, key_if.key_release}, 32'd0);

    check_eq("valid_err_overlap", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
